// File: rtl/car_parking_mux_pkg.sv
// Shared constants and helpers for the car-park occupancy unit:
// active-low 7-segment encodings and a binary-to-BCD converter.
package car_parking_pkg;

  localparam int unsigned BCD_MAX = 10;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Double-dabble over a 32-bit input; callers keep only the nibbles they need.
  function automatic logic [4*BCD_MAX-1:0] bin2bcd(input logic [31:0] bin);
    logic [4*BCD_MAX-1:0] bcd;
    logic [31:0]          sh;
    bcd = '0;
    sh  = bin;
    for (int unsigned i = 0; i < 32; i++) begin
      for (int unsigned d = 0; d < BCD_MAX; d++) begin
        if (bcd[4*d +: 4] > 4'd4) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      bcd = {bcd[4*BCD_MAX-2:0], sh[31]};
      sh  = {sh[30:0], 1'b0};
    end
    return bcd;
  endfunction

  function automatic seg_t seg_encode(input logic [3:0] d);
    return (d <= 4'd9) ? SEG_DIGIT[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/car_parking_mux_if.sv
// Sensor and display bundle of the car-park unit; slave is the unit side,
// master the board/driver side.
interface car_parking_mux_if #(
  parameter int unsigned N_SLOTS    = 8,
  parameter int unsigned NUM_DIGITS = 2
);
  localparam int unsigned CW = $clog2(N_SLOTS + 1);

  logic [N_SLOTS-1:0]    car;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] AN;
  logic [CW-1:0]         occupied;
  logic                  full;
  logic                  empty;
  logic                  arrive;
  logic                  depart;

  modport master (output car, input seg, AN, occupied, full, empty, arrive, depart);
  modport slave  (input car, output seg, AN, occupied, full, empty, arrive, depart);

endinterface

// File: rtl/car_parking_mux_debounce.sv
// One slot sensor: 2-FF synchroniser, stability counter and registered
// edge pulses that coincide with the debounced output changing.
module slot_debounce #(
  parameter int unsigned DEB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic q,
  output logic rise,
  output logic fall
);
  localparam int unsigned CNTW = $clog2(DEB_CYCLES);

  logic            meta_q, sync_q, deb_q, deb_d, rise_q, fall_q;
  logic [CNTW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_q != deb_q) begin
      if (cnt_q == CNTW'(DEB_CYCLES - 1)) deb_d = sync_q;
      else                                cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= d_async;
      sync_q <= meta_q;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
      rise_q <= deb_d & ~deb_q;
      fall_q <= ~deb_d & deb_q;
    end
  end

  assign q    = deb_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/car_parking_mux.sv
// Car-park occupancy unit: debounced slot sensors, occupancy count, flags,
// arrival/departure pulses and a multiplexed common-anode decimal display.
module car_parking_mux
  import car_parking_pkg::*;
#(
  parameter int unsigned N_SLOTS    = 8,
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned DEB_CYCLES = 1000,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned LZ_BLANK   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  car_parking_mux_if.slave bus
);
  localparam int unsigned CW = $clog2(N_SLOTS + 1);
  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [N_SLOTS-1:0] deb, rise, fall;

  for (genvar s = 0; s < N_SLOTS; s++) begin : g_slot
    slot_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_async(bus.car[s]),
      .q      (deb[s]),
      .rise   (rise[s]),
      .fall   (fall[s])
    );
  end

  logic [CW-1:0]         occ_q, occ_d;
  logic                  full_q, empty_q, arrive_q, depart_q;
  logic [PW-1:0]         pre_q, pre_d;
  logic [IW-1:0]         idx_q, idx_d;
  seg_t                  seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  always_comb begin
    occ_d = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) occ_d = occ_d + CW'(deb[i]);
  end

  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PW'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  logic [4*NUM_DIGITS-1:0] bcd;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    zero_above;
  logic [3:0]              nib;
  logic                    nib_blank;

  assign bcd = (4*NUM_DIGITS)'(bin2bcd(32'(occ_q)));

  // Walk digits from the top so a digit blanks only when all higher ones are zero.
  always_comb begin
    zero_above = 1'b1;
    blank      = '0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      zero_above = zero_above & (bcd[4*(NUM_DIGITS-1-j) +: 4] == 4'd0);
      blank[NUM_DIGITS-1-j] = (LZ_BLANK != 0) && (j != NUM_DIGITS - 1) && zero_above;
    end
    nib       = '0;
    nib_blank = 1'b0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if (idx_q == IW'(j)) begin
        nib       = bcd[4*j +: 4];
        nib_blank = blank[j];
      end
    end
    seg_d = nib_blank ? SEG_BLANK : seg_encode(nib);
    an_d  = ~(NUM_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      arrive_q <= 1'b0;
      depart_q <= 1'b0;
      pre_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_BLANK;
      an_q     <= '1;
    end else begin
      occ_q    <= occ_d;
      full_q   <= (occ_d == CW'(N_SLOTS));
      empty_q  <= (occ_d == '0);
      arrive_q <= |rise;
      depart_q <= |fall;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign bus.seg      = seg_q;
  assign bus.AN       = an_q;
  assign bus.occupied = occ_q;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.arrive   = arrive_q;
  assign bus.depart   = depart_q;

endmodule
